// File: rtl/multiplier.sv
// Pipelined unsigned multiplier, result = (a*b) mod 2^DATA_LEN.
// An input register samples a/b; PIPELINE_STAGE shift-add stages each consume one slice of b.
module multiplier #(
    parameter int DATA_LEN       = 32,
    parameter int PIPELINE_STAGE = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_LEN-1:0] a,
    input  logic [DATA_LEN-1:0] b,
    output logic [DATA_LEN-1:0] result
);
    localparam int SLICE = (DATA_LEN + PIPELINE_STAGE - 1) / PIPELINE_STAGE;

    // Operands, remaining b bits and running sum feeding each stage.
    logic [DATA_LEN-1:0] a_pipe   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] b_pipe   [PIPELINE_STAGE];
    logic [DATA_LEN-1:0] sum_pipe [PIPELINE_STAGE+1];

    logic [DATA_LEN-1:0] a_in_d, a_in_q;
    logic [DATA_LEN-1:0] b_in_d, b_in_q;

    always_comb begin
        a_in_d = a;
        b_in_d = b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_in_q <= '0;
            b_in_q <= '0;
        end else begin
            a_in_q <= a_in_d;
            b_in_q <= b_in_d;
        end
    end

    assign a_pipe[0]   = a_in_q;
    assign b_pipe[0]   = b_in_q;
    assign sum_pipe[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < PIPELINE_STAGE; gi++) begin : gen_stage
            localparam int BASE = gi * SLICE;

            logic [DATA_LEN-1:0] sum_d, sum_q;
            logic [DATA_LEN-1:0] a_cur, b_cur;

            // Bits of b at or above DATA_LEN are zero, so a short last slice falls out naturally.
            always_comb begin
                sum_d = sum_pipe[gi];
                a_cur = a_pipe[gi] << BASE;
                b_cur = b_pipe[gi];
                for (int j = 0; j < SLICE; j++) begin
                    if (b_cur[0]) begin
                        sum_d = sum_d + a_cur;
                    end
                    a_cur = a_cur << 1;
                    b_cur = b_cur >> 1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sum_q <= '0;
                end else begin
                    sum_q <= sum_d;
                end
            end

            assign sum_pipe[gi+1] = sum_q;

            if (gi < PIPELINE_STAGE - 1) begin : gen_fwd
                logic [DATA_LEN-1:0] a_d, a_q;
                logic [DATA_LEN-1:0] b_d, b_q;

                always_comb begin
                    a_d = a_pipe[gi];
                    b_d = b_pipe[gi] >> SLICE;
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end

                assign a_pipe[gi+1] = a_q;
                assign b_pipe[gi+1] = b_q;
            end
        end
    endgenerate

    assign result = sum_pipe[PIPELINE_STAGE];

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for multiplier: a 32-bit/2-stage instance plus 8-bit instances with 1, 3 and 8 stages.
module tb_multiplier;
    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a32   = '0;
    logic [31:0] b32   = '0;
    logic [7:0]  a8    = '0;
    logic [7:0]  b8    = '0;
    logic [31:0] r32;
    logic [7:0]  r8_1, r8_3, r8_8;

    int n_vec  = 0;
    int n_err  = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) u_m32 (
        .clk(clk), .reset(reset), .a(a32), .b(b32), .result(r32));
    multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(1)) u_m8_1 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .result(r8_1));
    multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(3)) u_m8_3 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .result(r8_3));
    multiplier #(.DATA_LEN(8), .PIPELINE_STAGE(8)) u_m8_8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .result(r8_8));

    logic [31:0] res_all [4];
    assign res_all[0] = r32;
    assign res_all[1] = {24'd0, r8_1};
    assign res_all[2] = {24'd0, r8_3};
    assign res_all[3] = {24'd0, r8_8};

    // One scoreboard per instance; a pair pushed before edge k is popped after edge k+LAT.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gen_sb
            localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 8;
            logic [31:0] exp_q [$];
            logic [31:0] e;

            task automatic restart();
                exp_q.delete();
                repeat (LAT) exp_q.push_back(32'd0);
            endtask

            always @(posedge clk) begin
                #1;
                if (mon_en && exp_q.size() > LAT) begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (res_all[gi] !== e) begin
                        n_err++;
                        $display("FAIL sb_lat%0d result=%h expected=%h t=%0t", LAT, res_all[gi], e, $time);
                    end else begin
                        $display("ok   sb_lat%0d result=%h t=%0t", LAT, res_all[gi], $time);
                    end
                end
            end
        end
    endgenerate

    localparam logic [31:0] VA [12] = '{32'd3, 32'd0, 32'hFFFF_FFFF, 32'h0001_0000, 32'd2, 32'd7,
                                        32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000,
                                        32'd1, 32'd0};
    localparam logic [31:0] VB [12] = '{32'd5, 32'd0, 32'd2, 32'h0001_0000, 32'd3, 32'd6,
                                        32'h0000_FFFF, 32'h0000_0010, 32'hFFFF_FFFF, 32'd3,
                                        32'hDEAD_BEEF, 32'd0};
    localparam logic [31:0] VP [12] = '{32'd15, 32'd0, 32'hFFFF_FFFE, 32'h0000_0000, 32'd6, 32'd42,
                                        32'hFFFE_0001, 32'h2345_6780, 32'h0000_0001, 32'h8000_0000,
                                        32'hDEAD_BEEF, 32'd0};
    localparam logic [7:0] WA [12] = '{8'd3, 8'd0, 8'd255, 8'd16, 8'd2, 8'd7,
                                       8'd255, 8'd15, 8'd128, 8'd1, 8'd13, 8'd20};
    localparam logic [7:0] WB [12] = '{8'd5, 8'd0, 8'd2, 8'd16, 8'd3, 8'd6,
                                       8'd255, 8'd17, 8'd3, 8'd200, 8'd13, 8'd13};
    localparam logic [7:0] WP [12] = '{8'd15, 8'd0, 8'd254, 8'd0, 8'd6, 8'd42,
                                       8'd1, 8'd255, 8'd128, 8'd200, 8'd169, 8'd4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s result=%h expected=%h t=%0t", name, act, exp, $time);
        end else begin
            $display("ok   %s result=%h t=%0t", name, act, $time);
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int k = 0; k < 4; k++) check(name, res_all[k], 32'd0);
    endtask

    // Called at a falling edge: releases reset and re-arms the scoreboards with an empty pipeline.
    task automatic release_reset();
        reset = 1'b0;
        gen_sb[0].restart();
        gen_sb[1].restart();
        gen_sb[2].restart();
        gen_sb[3].restart();
        mon_en = 1'b1;
    endtask

    // Called at a falling edge; applies one operand set for the next rising edge.
    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] p,
                         input logic [7:0] u, input logic [7:0] v, input logic [7:0] q);
        a32 = x;
        b32 = y;
        a8  = u;
        b8  = v;
        gen_sb[0].exp_q.push_back(p);
        gen_sb[1].exp_q.push_back({24'd0, q});
        gen_sb[2].exp_q.push_back({24'd0, q});
        gen_sb[3].exp_q.push_back({24'd0, q});
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rx, ry, rp;
        logic [7:0]  ux, uy, up;

        #1;
        check_all_zero("por_async");
        repeat (2) @(negedge clk);
        check_all_zero("por_held");

        release_reset();
        for (int i = 0; i < 12; i++) drive(VA[i], VB[i], VP[i], WA[i], WB[i], WP[i]);

        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = $urandom;
            rp = rx * ry;
            ux = 8'($urandom_range(0, 255));
            uy = 8'($urandom_range(0, 255));
            up = ux * uy;
            drive(rx, ry, rp, ux, uy, up);
        end

        // Reset lands after 25 is on the output but before 81 would reach it.
        drive(32'd5, 32'd5, 32'd25, 8'd5, 8'd5, 8'd25);
        drive(32'd9, 32'd9, 32'd81, 8'd9, 8'd9, 8'd81);
        drive(32'd0, 32'd0, 32'd0, 8'd0, 8'd0, 8'd0);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_clear");
        for (int i = 0; i < 3; i++) begin
            a32 = $urandom;
            b32 = $urandom | 32'd1;
            a8  = 8'($urandom_range(1, 255));
            b8  = 8'($urandom_range(1, 255));
            @(negedge clk);
            check_all_zero("reset_hold");
        end

        @(negedge clk);
        release_reset();
        for (int i = 0; i < 12; i++) drive(32'd0, 32'd0, 32'd0, 8'd0, 8'd0, 8'd0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 32, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter PIPELINE_STAGE, default 2, meaning the number of register stages from operand sampling to result (legal range 1..DATA_LEN).
REQ-003 The block SHALL have port clk, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset reset, asynchronous, active-high; clock clk.
REQ-005 The block SHALL have port a, input, DATA_LEN bits, the unsigned multiplicand.
REQ-006 The block SHALL have port b, input, DATA_LEN bits, the unsigned multiplier.
REQ-007 The block SHALL have port result, output, DATA_LEN bits, the registered product.

Function
REQ-008 result SHALL equal (a*b) mod 2^DATA_LEN, unsigned; upper product bits are discarded and no overflow flag exists.
REQ-009 a and b SHALL be sampled on every rising clk edge; there is no valid/ready handshake, and the inputs need be held for one cycle only.
REQ-010 Latency SHALL be exactly PIPELINE_STAGE cycles: operands sampled at edge k appear on result after edge k+PIPELINE_STAGE and remain until edge k+PIPELINE_STAGE+1.
REQ-011 The block SHALL be fully pipelined with throughput one product per cycle; back-to-back operand pairs SHALL produce back-to-back results in order.
REQ-012 The work SHALL be split across stages as shift-add partial products: stage i accumulates the partial products for its slice of b, and each slice SHALL be ceil(DATA_LEN/PIPELINE_STAGE) bits wide, the last slice taking the remainder.
REQ-013 Each stage SHALL carry forward a, the not-yet-consumed bits of b and a DATA_LEN-bit running sum truncated mod 2^DATA_LEN.
REQ-014 result SHALL be driven directly from the final stage register, with no combinational path from a or b to result.
REQ-015 Operands of zero SHALL yield a result of zero after the latency; this case is indistinguishable from the idle or post-reset output.
REQ-016 When PIPELINE_STAGE=1, the block SHALL compute the whole product in one stage and register it.

Reset
REQ-017 Asserting reset SHALL immediately, without waiting for clk, clear every pipeline register and drive result to 0.
REQ-018 Reset mid-operation SHALL discard all in-flight products; none of them SHALL ever appear on result.
REQ-019 After reset deasserts, the first operands sampled SHALL appear PIPELINE_STAGE cycles later; until then result SHALL hold 0.
REQ-020 While reset is held high, result SHALL remain 0 regardless of a and b.

Verification
REQ-021 Basic latency: a=3, b=5 for one cycle, then a=b=0 -> result=15 exactly 2 cycles after sampling, then 0 on the following cycle.
REQ-022 Truncation: a=0xFFFFFFFF, b=2 -> result=0xFFFFFFFE; a=0x00010000, b=0x00010000 -> result=0x00000000.
REQ-023 Pipelining: pairs (2,3), (7,6), (0xFFFF,0xFFFF) on consecutive cycles -> results 6, 42, 0xFFFE0001 on consecutive cycles, in that order.
REQ-024 Reset mid-flight: apply a=9, b=9, then assert reset asynchronously one cycle later -> result goes to 0 at once and 81 never appears.
REQ-025 Parameter sweep: DATA_LEN=8 with PIPELINE_STAGE=1, 3 and 8, random operands -> result = (a*b) mod 256 at exactly PIPELINE_STAGE cycles latency.
